// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one GO/END/ACK I2C frame controller
// between N_REQ requesters, with NACK retry, inter-attempt gap and per-requester
// completion/error status. Optional watchdog enabled by macro I2C_ARB_WDOG_EN.
//
// Ports:
//   iCLK       block clock, same as the I2C controller
//   iRST_N     asynchronous active-low reset
//   iREQ       level request per requester
//   iREQ_DATA  24-bit frame of requester i at [24*i+23:24*i]
//   oDONE      one-cycle completion pulse, one-hot on the served requester
//   oERR       valid with oDONE: 1 = retries exhausted or watchdog expired
//   oBUSY      high whenever a grant is in progress
//   oI2C_DATA  latched frame presented to the controller
//   oI2C_GO    controller start
//   iI2C_END   controller end flag (high when idle)
//   iI2C_ACK   controller ack result (1 = NACK)
module i2c_cmd_arbiter #(
   parameter int N_REQ     = 3,
   parameter int MAX_RETRY = 3,
   parameter int GAP_CYC   = 4,
   parameter int WDOG_CYC  = 1024
) (
   input  logic                 iCLK,
   input  logic                 iRST_N,
   input  logic [N_REQ-1:0]     iREQ,
   input  logic [24*N_REQ-1:0]  iREQ_DATA,
   output logic [N_REQ-1:0]     oDONE,
   output logic                 oERR,
   output logic                 oBUSY,
   output logic [23:0]          oI2C_DATA,
   output logic                 oI2C_GO,
   input  logic                 iI2C_END,
   input  logic                 iI2C_ACK
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [2:0] {IDLE, LAUNCH, XFER, GAP, DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] rr_ptr, grant, pick;
   logic [IW:0] sum;
   logic hit;
   logic [3:0] retry_cnt;
   logic [7:0] gap_cnt;
   logic err;
   logic wdog_hit;
`ifdef I2C_ARB_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog_cnt;
   // Cleared on every entry to LAUNCH so each attempt gets the full budget.
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) wdog_cnt <= '0;
      else if (state_n == LAUNCH && state != LAUNCH) wdog_cnt <= '0;
      else if (state == LAUNCH || state == XFER) wdog_cnt <= wdog_cnt + WW'(1);
   assign wdog_hit = (state == LAUNCH || state == XFER) && wdog_cnt == WW'(WDOG_CYC - 1);
`else
   assign wdog_hit = 1'b0;
`endif
   // Scan from highest offset down so the lowest offset after rr_ptr wins.
   always_comb begin
      hit = 1'b0;
      pick = rr_ptr;
      sum = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
         if (iREQ[sum[IW-1:0]]) begin
            hit = 1'b1;
            pick = sum[IW-1:0];
         end
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = hit ? LAUNCH : IDLE;
         LAUNCH:  state_n = wdog_hit ? DONE : (!iI2C_END ? XFER : LAUNCH);
         XFER:    state_n = wdog_hit ? DONE :
                            !iI2C_END ? XFER :
                            (iI2C_ACK && retry_cnt < 4'(MAX_RETRY)) ? GAP : DONE;
         GAP:     state_n = (gap_cnt == 8'd1) ? LAUNCH : GAP;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         state     <= IDLE;
         rr_ptr    <= IW'(N_REQ - 1);
         grant     <= '0;
         retry_cnt <= '0;
         gap_cnt   <= '0;
         err       <= 1'b0;
         oI2C_DATA <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && hit) begin
            oI2C_DATA <= iREQ_DATA[24*int'(pick) +: 24];
            grant     <= pick;
            rr_ptr    <= pick;
            retry_cnt <= '0;
         end
         if (state == XFER && state_n == GAP) begin
            retry_cnt <= retry_cnt + 4'd1;
            gap_cnt   <= 8'(GAP_CYC);
         end
         if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
         // Entering DONE from LAUNCH is only possible via the watchdog.
         if (state_n == DONE && state != DONE) err <= wdog_hit | iI2C_ACK;
      end
   // GO falls in the same cycle END returns so the controller cannot restart.
   assign oI2C_GO = (state == LAUNCH) || (state == XFER && !iI2C_END);
   assign oBUSY   = state != IDLE;
   assign oDONE   = (state == DONE) ? N_REQ'(1) << grant : '0;
   assign oERR    = (state == DONE) && err;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] req = '0;
   logic [71:0] req_data = '0;
   logic [2:0] done;
   logic err, busy, go;
   logic [23:0] i2c_data;
   logic m_end, m_ack;
   logic stuck = 1'b0;
   logic clr = 1'b0;
   int nack_plan = 0;
   int checks = 0;
   int errors = 0;
   logic [7:0] m_cnt, att;
   int sessions, idle_run, gap_min;
   logic go_q, first;
   logic multi = 1'b0;
   always #5 clk = ~clk;
   i2c_cmd_arbiter #(.N_REQ(3), .MAX_RETRY(3), .GAP_CYC(4), .WDOG_CYC(64)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iREQ_DATA(req_data),
      .oDONE(done), .oERR(err), .oBUSY(busy), .oI2C_DATA(i2c_data),
      .oI2C_GO(go), .iI2C_END(m_end), .iI2C_ACK(m_ack)
   );
   // Controller model: 4-cycle transfer; NACKs the first nack_plan attempts of a grant.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_end <= 1'b1;
         m_ack <= 1'b0;
         m_cnt <= '0;
         att   <= '0;
      end else if (|done) att <= '0;
      else if (!m_end) begin
         if (m_cnt == 0) begin
            m_end <= 1'b1;
            m_ack <= (int'(att) <= nack_plan);
         end else m_cnt <= m_cnt - 8'd1;
      end else if (go && !stuck) begin
         m_end <= 1'b0;
         m_cnt <= 8'd3;
         att   <= att + 8'd1;
      end
   // GO session counter and minimum idle gap between sessions of one run.
   always @(posedge clk) begin
      go_q <= go;
      if (clr) begin
         sessions <= 0;
         idle_run <= 0;
         gap_min  <= 255;
         first    <= 1'b1;
      end else begin
         if (go && !go_q) begin
            sessions <= sessions + 1;
            if (!first && idle_run < gap_min) gap_min <= idle_run;
            first <= 1'b0;
         end
         idle_run <= go ? 0 : idle_run + 1;
      end
   end
   always @(negedge clk) if (!$onehot0(done)) multi <= 1'b1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_done(output logic [2:0] d, output logic e);
      d = '0;
      e = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (|done) begin
            d = done;
            e = err;
            return;
         end
      end
   endtask
   task automatic clear_stats();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask
   initial begin
      logic [2:0] d;
      logic e, found, saw;
      int n;
      repeat (2) @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", i2c_data, 0);
      chk("rst_go", go, 0);
      rst_n = 1'b1;
      clear_stats();
      // single request, frame change after grant must be ignored
      req_data[23:0] = 24'h341201;
      req = 3'b001;
      @(negedge clk);
      chk("grant_busy", busy, 1);
      chk("grant_go", go, 1);
      req_data[23:0] = 24'hFFFFFF;
      wait_done(d, e);
      chk("single_done", d, 3'b001);
      chk("single_err", e, 0);
      chk("single_data", i2c_data, 24'h341201);
      chk("single_sessions", sessions, 1);
      req = '0;
      @(negedge clk);
      chk("single_done_low", done, 0);
      chk("single_err_low", err, 0);
      chk("single_idle", busy, 0);
      // simultaneous requests after reset: order 0,1,2
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      req_data = {24'h40052C, 24'h4A0C10, 24'h341201};
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         wait_done(d, e);
         chk("rr_order", d, 32'd1 << i);
         chk("rr_data", i2c_data, req_data[24*i +: 24]);
         req[i] = 1'b0;
      end
      req = 3'b010;
      wait_done(d, e);
      chk("rr_req1_again", d, 3'b010);
      req = 3'b101;
      wait_done(d, e);
      chk("rr_after1_is2", d, 3'b100);
      req[2] = 1'b0;
      wait_done(d, e);
      chk("rr_then0", d, 3'b001);
      req = '0;
      // NACK recovery: two NACKs then ACK
      nack_plan = 2;
      clear_stats();
      req = 3'b001;
      wait_done(d, e);
      chk("nack_done", d, 3'b001);
      chk("nack_err", e, 0);
      chk("nack_sessions", sessions, 3);
      chk("nack_gap", gap_min >= 4, 1);
      req = '0;
      // persistent NACK: 1 + MAX_RETRY attempts then error
      nack_plan = 15;
      clear_stats();
      req = 3'b001;
      wait_done(d, e);
      chk("pers_done", d, 3'b001);
      chk("pers_err", e, 1);
      chk("pers_sessions", sessions, 4);
      chk("pers_gap", gap_min >= 4, 1);
      req = '0;
      @(negedge clk);
      chk("pers_idle", busy, 0);
      // reset in the middle of a transfer
      nack_plan = 0;
      req = 3'b001;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         found = go && !m_end;
      end
      chk("mid_xfer_reached", found, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_go", go, 0);
      chk("mid_rst_busy", busy, 0);
      req = '0;
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw = saw | (|done);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         saw = saw | (|done);
      end
      chk("mid_rst_no_done", saw, 0);
      req = 3'b010;
      wait_done(d, e);
      chk("post_rst_done", d, 3'b010);
      chk("post_rst_err", e, 0);
      req = '0;
`ifdef I2C_ARB_WDOG_EN
      // stuck controller: END never falls
      stuck = 1'b1;
      clear_stats();
      req = 3'b001;
      @(negedge clk);
      chk("wdog_launch", go, 1);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (!go) break;
      end
      chk("wdog_cycles", n, 64);
      chk("wdog_done", done, 3'b001);
      chk("wdog_err", err, 1);
      req = '0;
      @(negedge clk);
      chk("wdog_idle", busy, 0);
      chk("wdog_sessions", sessions, 1);
      stuck = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("done_onehot", multi, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one GO/END/ACK I2C frame controller (24-bit frame: slave addr, sub addr, data) between N_REQ requesters, e.g. the power-up codec config sequencer, runtime volume control and video-decoder setup.
- Round-robin arbitration, frame latching, NACK retry with inter-attempt gap, per-requester completion and error status.
- Sits between the requesters and the I2C controller, in the controller's clock domain.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_RETRY, 3, extra attempts after a NACK before reporting an error (0..15).
- GAP_CYC, 4, idle cycles between a NACK and the relaunch (1..255).
- WDOG_CYC, 1024, watchdog limit in cycles. Used only with I2C_ARB_WDOG_EN.

Ports:
- iCLK  in  1  block clock; the same clock as the I2C controller.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  N_REQ  level request per requester.
- iREQ_DATA  in  24*N_REQ  frame of requester i at bits [24*i+23:24*i].
- oDONE  out  N_REQ  one-cycle completion pulse per requester.
- oERR  out  1  valid with oDONE: 1 = failed (retries exhausted or watchdog).
- oBUSY  out  1  high in any state except IDLE.
- oI2C_DATA  out  24  frame to the controller.
- oI2C_GO  out  1  controller start.
- iI2C_END  in  1  controller end flag: high when idle, low during a transfer.
- iI2C_ACK  in  1  controller ack result: 0 = all bytes acked, 1 = NACK.

Behaviour:
- Reset values: oDONE=0, oERR=0, oBUSY=0, oI2C_DATA=0, oI2C_GO=0. Internal: state=IDLE, rr_ptr=N_REQ-1, retry_cnt=0, gap_cnt=0.
- States: IDLE, LAUNCH, XFER, GAP, DONE.
- IDLE:
  - If any iREQ bit is high, grant the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - On grant: latch the granted slice into oI2C_DATA, store the grant index, set rr_ptr to that index, clear retry_cnt, go to LAUNCH.
  - The grant decision takes 1 cycle.
- LAUNCH:
  - oI2C_GO=1.
  - When iI2C_END=0 (controller has started), go to XFER.
- XFER:
  - oI2C_GO stays 1.
  - When iI2C_END=1: drop oI2C_GO and sample iI2C_ACK.
  - ACK=0: go to DONE with err=0.
  - ACK=1 and retry_cnt<MAX_RETRY: increment retry_cnt, load gap_cnt=GAP_CYC, go to GAP.
  - ACK=1 and retry_cnt=MAX_RETRY: go to DONE with err=1.
- GAP:
  - oI2C_GO=0; gap_cnt decrements each cycle.
  - At gap_cnt=1, go to LAUNCH. oI2C_DATA is unchanged; the frame is not re-read from iREQ_DATA.
- DONE:
  - For exactly 1 cycle: oDONE[grant]=1 and oERR=err.
  - Next state IDLE. oERR returns to 0 when oDONE falls.
- Minimum turnaround between back-to-back grants is 2 cycles (DONE, then the IDLE grant cycle).
- Total attempts per grant = 1 + MAX_RETRY.
- Requester rules:
  - Hold iREQ until its oDONE pulse, then deassert the next cycle. A level still high in IDLE after DONE is a new request.
  - iREQ dropped before grant: the request is forgotten.
  - iREQ dropped after grant: the transfer completes and oDONE still pulses.
  - iREQ_DATA changes after grant have no effect.
- Fairness: under continuous requests from all N_REQ requesters, grant order is strictly cyclic. No requester waits more than N_REQ-1 transfers.
- Reset mid-operation: all outputs and state return to reset values immediately. oI2C_GO=0 aborts the controller. No oDONE is issued for the aborted grant.
- Only one oDONE bit may be high in any cycle.

Optional Feature:
- Macro: I2C_ARB_WDOG_EN.
- When defined:
  - A counter clears on entry to LAUNCH and counts while in LAUNCH or XFER.
  - On reaching WDOG_CYC, drop oI2C_GO, go to DONE with err=1, and issue no retry.
  - Guards against a stuck controller or missing device clock stretch.
- When undefined: no counter is built and LAUNCH/XFER wait indefinitely.

Test Plan:
- Single request: iREQ=3'b001, iREQ_DATA[23:0]=24'h341201; controller model acks → oI2C_DATA=24'h341201, one GO session, oDONE=3'b001 for 1 cycle, oERR=0, oBUSY=0 afterwards.
- Simultaneous: iREQ=3'b111 held, each dropped after its oDONE, all acked → grant order 0,1,2; then req1 re-asserted → granted next with rr_ptr=2.
- NACK recovery: model NACKs the first 2 attempts, acks the 3rd (MAX_RETRY=3) → 3 GO sessions, each ≥GAP_CYC=4 idle cycles apart, oDONE with oERR=0.
- Persistent NACK: model always NACKs → exactly 4 GO sessions, then oDONE with oERR=1, back to IDLE.
- Reset mid-XFER: iRST_N low for 2 cycles during a transfer → oI2C_GO=0 and oBUSY=0 immediately, no oDONE; a new request after reset completes normally.
- Watchdog (I2C_ARB_WDOG_EN, WDOG_CYC=64): model never drops iI2C_END → GO deasserted at cycle 64 after LAUNCH entry, oDONE with oERR=1, no retry.
